// File: rtl/cpu_pkg.sv
// Definitions shared across the CPU: fetch FSM encoding, boot constants and
// the instruction/data address-error detect.
package cpu_pkg;

  typedef enum logic [1:0] {
    F_REQ     = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2,
    F_FULL    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] CPU_RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  // Word accesses fault when either low address bit is set.
  function automatic logic addr_err(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_state.sv
// Instruction fetch stage: one-at-a-time SRAM-like initiator, instruction
// register toward decode, and exception redirect with response discard.
module fetch_state
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Clr_n,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic [31:0] D_NewPC,
  input  logic        D_stall,
  input  logic        dm_stall,
  input  logic        exp_flush,
  input  logic [31:0] exception_new_pc,
  output logic [31:0] I_PC,
  output logic [31:0] I_PC_Pass,
  output logic [31:0] I_MipsInstr,
  output logic        I_nextNotReady,
  output logic        I_inst_illegal
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic         ir_illegal_q, ir_illegal_d;
  logic         redirect_pending_q, redirect_pending_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         req_q, req_d;
  logic         accept;

  assign accept = (state_q == F_FULL) && !D_stall && !dm_stall && !exp_flush;

  always_comb begin
    state_d            = state_q;
    fetch_pc_d         = fetch_pc_q;
    ir_d               = ir_q;
    ir_pc_d            = ir_pc_q;
    ir_valid_d         = ir_valid_q;
    ir_illegal_d       = ir_illegal_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;

    case (state_q)
      F_REQ: begin
        if (!req_q) begin
          // Nothing on the bus yet (post-reset cycle or misaligned PC), so a redirect can apply directly.
          if (exp_flush) begin
            fetch_pc_d = exception_new_pc;
          end else if (addr_err(fetch_pc_q[1:0])) begin
            ir_d         = NOP_INSTR;
            ir_pc_d      = fetch_pc_q;
            ir_illegal_d = 1'b1;
            ir_valid_d   = 1'b1;
            state_d      = F_FULL;
          end
        end else begin
          if (exp_flush) begin
            redirect_pending_d = 1'b1;
            redirect_pc_d      = exception_new_pc;
          end
          if (inst_sram_addr_ok) begin
            state_d = (exp_flush || redirect_pending_q) ? F_DISCARD : F_WAIT;
          end
        end
      end

      F_WAIT: begin
        if (exp_flush) begin
          fetch_pc_d = exception_new_pc;
          state_d    = inst_sram_data_ok ? F_REQ : F_DISCARD;
        end else if (inst_sram_data_ok) begin
          ir_d         = inst_sram_rdata;
          ir_pc_d      = fetch_pc_q;
          ir_illegal_d = 1'b0;
          ir_valid_d   = 1'b1;
          state_d      = F_FULL;
        end
      end

      F_DISCARD: begin
        if (exp_flush) begin
          // A flush coinciding with the dropped response redirects at once.
          if (inst_sram_data_ok) begin
            fetch_pc_d         = exception_new_pc;
            redirect_pending_d = 1'b0;
            state_d            = F_REQ;
          end else begin
            redirect_pending_d = 1'b1;
            redirect_pc_d      = exception_new_pc;
          end
        end else if (inst_sram_data_ok) begin
          if (redirect_pending_q) begin
            fetch_pc_d         = redirect_pc_q;
            redirect_pending_d = 1'b0;
          end
          state_d = F_REQ;
        end
      end

      F_FULL: begin
        if (exp_flush) begin
          ir_valid_d = 1'b0;
          fetch_pc_d = exception_new_pc;
          state_d    = F_REQ;
        end else if (accept) begin
          ir_valid_d = 1'b0;
          fetch_pc_d = D_NewPC;
          state_d    = F_REQ;
        end
      end

      default: state_d = F_REQ;
    endcase

    req_d = (state_d == F_REQ) && !addr_err(fetch_pc_d[1:0]);
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q            <= F_REQ;
      fetch_pc_q         <= RESET_PC;
      ir_q               <= NOP_INSTR;
      ir_pc_q            <= 32'h0;
      ir_valid_q         <= 1'b0;
      ir_illegal_q       <= 1'b0;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= 32'h0;
      req_q              <= 1'b0;
    end else begin
      state_q            <= state_d;
      fetch_pc_q         <= fetch_pc_d;
      ir_q               <= ir_d;
      ir_pc_q            <= ir_pc_d;
      ir_valid_q         <= ir_valid_d;
      ir_illegal_q       <= ir_illegal_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
      req_q              <= req_d;
    end
  end

  assign inst_sram_req  = req_q;
  assign inst_sram_addr = fetch_pc_q;
  assign I_PC           = ir_pc_q;
  assign I_PC_Pass      = ir_pc_q;
  assign I_MipsInstr    = ir_valid_q ? ir_q : NOP_INSTR;
  assign I_nextNotReady = !ir_valid_q;
  assign I_inst_illegal = ir_valid_q && ir_illegal_q;

endmodule
